id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised, registered decode stage for the RV32 pipeline. It replaces the purely combinational decode path with an ID/EX output register under valid/ready handshakes on both sides, plus flush and an internal load-use interlock. It also adds an optional writeback-to-decode operand bypass and a stall-cycle counter. It sits between the fetch stage and EX, and instantiates the existing register_file, immediate_generator and controller.

## Interface
Parameters:
- NREGS, 32, architectural register count (32 = RV32I, 16 = RV32E); allowed values are 16 and 32 only.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard the held and incoming instruction.
- if_valid  in  1  fetch offers if_instr/if_pc.
- if_ready  out  1  decode accepts this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  32  instruction PC.
- wb_reg_write  in  1  writeback enable.
- wb_reg_write_rd  in  5  writeback destination.
- wb_reg_write_data  in  32  writeback data.
- id_valid  out  1  ID/EX register holds an instruction.
- id_ready  in  1  EX accepts this cycle.
- id_pc  out  32  registered PC.
- id_rs1, id_rs2, id_rd  out  5 each  registered register indices.
- id_rd1, id_rd2  out  32 each  registered operands.
- id_imm  out  32  registered immediate.
- id_branch_target  out  32  registered id_pc + id_imm, modulo 2^32.
- id_ctrl  out  28  registered control bundle, MSB to LSB: funct7[27:21], funct3[20:18], branch[17], jump[16], jump_src[15], alu_op[14:13], alu_src_a[12], alu_src_b[11:10], mem_write[9], mem_read[8], mem_data_mask[7:4], mem_read_sign_extend[3], reg_write[2], reg_write_src[1:0].
- id_illegal_reg  out  1  registered: an rs1/rs2/rd index is >= NREGS.
- id_stall_cnt  out  CNT_W  saturating count of stalled fetch cycles.

## Operation
- Decode is combinational from if_instr. A transfer (if_valid && if_ready) loads the whole payload into the ID/EX register and sets id_valid.
- Output transfer occurs when id_valid && id_ready. If there is no input transfer in the same cycle, id_valid clears; payload registers keep their value.
- Load-use interlock. Condition: id_valid, id_ctrl.mem_read=1, id_rd != 0, and the incoming instruction reads id_rd (rs1 or rs2, per controller usage).
  - While the condition holds, if_ready=0.
  - When the load transfers out, the register takes a bubble: id_valid=0 for one cycle. The dependent instruction is accepted the following cycle.
- if_ready = !rst && (flush || ((!id_valid || id_ready) && !load_use)).
- Flush (priority over everything except rst):
  - id_valid clears next edge.
  - The incoming instruction is consumed and dropped (if_ready=1).
  - Load-use is ignored.
- Register indices >= NREGS:
  - Reads return 0.
  - WB writes to them are ignored.
  - id_illegal_reg=1 in the registered payload.
- x0 always reads 0 and is never bypassed.
- id_stall_cnt increments each cycle with if_valid && !if_ready && !flush. It saturates at 2^CNT_W-1.

## Timing
- Latency: one cycle from input transfer to id_valid=1.
- Throughput: one instruction per cycle when id_ready stays high and no load-use occurs.
- id_valid holds, and the payload is stable, while id_ready=0. No payload change occurs without a transfer, except the bypass update below.
- Reset: id_valid=0, all payload outputs 0, id_illegal_reg=0, id_stall_cnt=0. if_ready=0 while rst=1.
- Reset mid-operation: the held instruction is lost; there is no partial state.
- Simultaneous output and input transfer: the new payload replaces the old in the same edge, with no bubble.
- Register-file write from WB lands at the clock edge; without bypass, a same-cycle read returns the old value.

## Configuration
- Macro ID_WB_BYPASS_EN, defined:
  - On input transfer, if wb_reg_write && wb_reg_write_rd == rs (nonzero, < NREGS), the captured operand is wb_reg_write_data.
  - While id_valid && !id_ready, a matching WB write also updates the held id_rd1/id_rd2.
- Macro not defined:
  - Operands are the raw register-file read.
  - Held operands never change.
  - EX forwarding must cover the same-cycle and held-stale cases.

## Test plan
- Reset, then stream of 4 ADDI instructions with id_ready=1 → id_valid rises 1 cycle after the first, 4 consecutive transfers, id_stall_cnt=0.
- LW x5 then ADD x6,x5,x1 back-to-back → if_ready=0 for 1 cycle, one bubble (id_valid=0), ADD accepted next cycle, id_stall_cnt=1.
- LW x0 followed by ADD x6,x0,x1 → no stall.
- id_ready=0 for 3 cycles with if_valid=1 → payload stable, if_ready=0, id_stall_cnt=3.
- Under ID_WB_BYPASS_EN: held instruction reads x7 and WB writes x7=0xDEADBEEF during a stall → id_rd1=0xDEADBEEF next cycle.
  - Without the macro: id_rd1 is unchanged.
- Flush while holding a valid instruction and if_valid=1 → id_valid=0 next cycle, incoming dropped.
- NREGS=16 with ADD x20,x17,x1 → id_illegal_reg=1, id_rd1=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe -- registered RV32 decode stage (ID/EX register).
//
// Decodes if_instr combinationally, reads the register file and builds the
// immediate. The result is captured into the ID/EX register under a
// valid/ready handshake on both sides. Also included:
//   - flush: drops the held instruction and consumes the incoming one.
//   - load-use interlock: a one-cycle bubble after a load whose rd is read
//     by the next instruction.
//   - saturating stall-cycle counter.
//
// Optional feature: define ID_WB_BYPASS_EN to forward writeback data into the
// captured operands, and into held operands while EX is stalled.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    discard held + incoming instruction
//   if_valid/if_ready        fetch-side handshake; if_instr, if_pc payload
//   wb_reg_write*            writeback port into the register file
//   id_valid/id_ready        EX-side handshake
//   id_pc, id_rs1/2, id_rd   registered PC and register indices
//   id_rd1/2, id_imm         registered operands and immediate
//   id_branch_target         registered id_pc + id_imm
//   id_ctrl                  registered 28-bit control bundle
//   id_illegal_reg           a used register index is >= NREGS
//   id_stall_cnt             saturating count of stalled fetch cycles
//
// Sub-modules in this file: register_file, immediate_generator, controller.
// NREGS must be 16 (RV32E) or 32 (RV32I).

// Register file: x0 hard-wired to zero, indices >= NREGS read 0 and ignore
// writes. Writes land at the clock edge (no internal write-through).
module register_file #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  localparam int         AW = $clog2(NREGS);
  localparam logic [5:0] NR = 6'(NREGS);

  logic [31:0] regs [NREGS];
  logic        w_ok, r1_ok, r2_ok;

  assign w_ok  = we && (waddr != 5'd0) && ({1'b0, waddr} < NR);
  assign r1_ok = (raddr1 != 5'd0) && ({1'b0, raddr1} < NR);
  assign r2_ok = (raddr2 != 5'd0) && ({1'b0, raddr2} < NR);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (w_ok) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata1 = r1_ok ? regs[raddr1[AW-1:0]] : '0;
  assign rdata2 = r2_ok ? regs[raddr2[AW-1:0]] : '0;
endmodule

// Immediate generator: sign-extended I/S/B/U/J immediates chosen by opcode.
// R-type and unknown opcodes yield 0.
module immediate_generator (
  input  logic [31:0] instr,
  output logic [31:0] imm
);
  always_comb begin
    imm = '0;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        imm = {{20{instr[31]}}, instr[31:20]};
      7'b0100011:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      7'b1100011:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {instr[31:12], 12'b0};
      7'b1101111:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

// Controller. Field encodings:
//   alu_op        00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
//   alu_src_a     0 rs1, 1 pc
//   alu_src_b     00 rs2, 01 imm
//   jump_src      0 pc-relative (JAL), 1 rs1-relative (JALR)
//   reg_write_src 00 alu, 01 memory, 10 pc+4, 11 immediate (LUI)
//   mem_data_mask byte 0001, half 0011, word 1111
// uses_rs1/uses_rs2 say which source fields are real register reads; they
// qualify both the load-use interlock and the illegal-index check.
module controller (
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [27:0] ctrl,
  output logic        uses_rs1,
  output logic        uses_rs2
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic       branch, jump, jump_src, alu_src_a, mem_write, mem_read;
  logic       sext, reg_write;
  logic [1:0] alu_op, alu_src_b, wb_src;
  logic [3:0] mask, size_mask;

  always_comb begin
    case (funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  always_comb begin
    branch = 1'b0; jump = 1'b0; jump_src = 1'b0; alu_src_a = 1'b0;
    mem_write = 1'b0; mem_read = 1'b0; sext = 1'b0; reg_write = 1'b0;
    alu_op = 2'b00; alu_src_b = 2'b00; wb_src = 2'b00; mask = 4'b0000;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0;
    case (opcode)
      OP_LUI:   begin reg_write = 1'b1; wb_src = 2'b11; end
      OP_AUIPC: begin alu_src_a = 1'b1; alu_src_b = 2'b01; reg_write = 1'b1; end
      OP_JAL:   begin jump = 1'b1; reg_write = 1'b1; wb_src = 2'b10; end
      OP_JALR:  begin
        jump = 1'b1; jump_src = 1'b1; alu_src_b = 2'b01;
        reg_write = 1'b1; wb_src = 2'b10; uses_rs1 = 1'b1;
      end
      OP_BR:    begin branch = 1'b1; alu_op = 2'b01; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_LOAD:  begin
        alu_src_b = 2'b01; mem_read = 1'b1; mask = size_mask; sext = !funct3[2];
        reg_write = 1'b1; wb_src = 2'b01; uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        alu_src_b = 2'b01; mem_write = 1'b1; mask = size_mask;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_IMM:   begin alu_op = 2'b11; alu_src_b = 2'b01; reg_write = 1'b1; uses_rs1 = 1'b1; end
      OP_REG:   begin alu_op = 2'b10; reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      default:  ;
    endcase
  end

  assign ctrl = {funct7, funct3, branch, jump, jump_src, alu_op, alu_src_a, alu_src_b,
                 mem_write, mem_read, mask, sext, reg_write, wb_src};
endmodule

module id_stage_pipe #(
  parameter int NREGS = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_reg_write_rd,
  input  logic [31:0]      wb_reg_write_data,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_pc,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [4:0]       id_rd,
  output logic [31:0]      id_rd1,
  output logic [31:0]      id_rd2,
  output logic [31:0]      id_imm,
  output logic [31:0]      id_branch_target,
  output logic [27:0]      id_ctrl,
  output logic             id_illegal_reg,
  output logic [CNT_W-1:0] id_stall_cnt
);
  localparam logic [5:0] NR = 6'(NREGS);
  localparam int CTRL_MEM_READ  = 8;
  localparam int CTRL_REG_WRITE = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] btgt;
    logic [27:0] ctrl;
    logic        illegal;
  } id_payload_t;

  id_payload_t      dec, id_q;
  logic             vld_q;
  logic [CNT_W-1:0] stall_q;

  logic [4:0]  rs1, rs2, rd;
  logic [27:0] ctrl;
  logic        uses_rs1, uses_rs2;
  logic [31:0] imm, rf_rd1, rf_rd2, op1, op2;
  logic        load_use, in_xfer, out_xfer;

  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign rd  = if_instr[11:7];

  register_file #(.NREGS(NREGS)) u_rf (
    .clk(clk), .rst(rst),
    .we(wb_reg_write), .waddr(wb_reg_write_rd), .wdata(wb_reg_write_data),
    .raddr1(rs1), .raddr2(rs2), .rdata1(rf_rd1), .rdata2(rf_rd2)
  );

  immediate_generator u_imm (.instr(if_instr), .imm(imm));

  controller u_ctrl (
    .opcode(if_instr[6:0]), .funct3(if_instr[14:12]), .funct7(if_instr[31:25]),
    .ctrl(ctrl), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2)
  );

`ifdef ID_WB_BYPASS_EN
  // WB data overrides a same-cycle regfile read, and refreshes held operands
  // while EX stalls, so EX never sees a value older than the last writeback.
  logic wb_ok, byp1, byp2, hold1, hold2;
  assign wb_ok = wb_reg_write && (wb_reg_write_rd != 5'd0) && ({1'b0, wb_reg_write_rd} < NR);
  assign byp1  = wb_ok && (wb_reg_write_rd == rs1);
  assign byp2  = wb_ok && (wb_reg_write_rd == rs2);
  assign hold1 = wb_ok && (wb_reg_write_rd == id_q.rs1);
  assign hold2 = wb_ok && (wb_reg_write_rd == id_q.rs2);
  assign op1   = byp1 ? wb_reg_write_data : rf_rd1;
  assign op2   = byp2 ? wb_reg_write_data : rf_rd2;
`else
  assign op1 = rf_rd1;
  assign op2 = rf_rd2;
`endif

  always_comb begin
    dec         = '0;
    dec.pc      = if_pc;
    dec.rs1     = rs1;
    dec.rs2     = rs2;
    dec.rd      = rd;
    dec.rd1     = op1;
    dec.rd2     = op2;
    dec.imm     = imm;
    dec.btgt    = if_pc + imm;
    dec.ctrl    = ctrl;
    dec.illegal = (uses_rs1 && ({1'b0, rs1} >= NR)) ||
                  (uses_rs2 && ({1'b0, rs2} >= NR)) ||
                  (ctrl[CTRL_REG_WRITE] && ({1'b0, rd} >= NR));
  end

  // Held load's result is not available yet: hold off a dependent reader.
  // The interlock persists through the load's output transfer, which is
  // what produces the single bubble.
  assign load_use = vld_q && id_q.ctrl[CTRL_MEM_READ] && (id_q.rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == id_q.rd)) || (uses_rs2 && (rs2 == id_q.rd)));

  assign if_ready = !rst && (flush || ((!vld_q || id_ready) && !load_use));
  assign in_xfer  = if_valid && if_ready && !flush;
  assign out_xfer = vld_q && id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      id_q    <= '0;
      stall_q <= '0;
    end else begin
      if (flush) begin
        vld_q <= 1'b0;
      end else if (in_xfer) begin
        vld_q <= 1'b1;
        id_q  <= dec;
      end else if (out_xfer) begin
        vld_q <= 1'b0;
`ifdef ID_WB_BYPASS_EN
      end else if (vld_q) begin
        if (hold1) id_q.rd1 <= wb_reg_write_data;
        if (hold2) id_q.rd2 <= wb_reg_write_data;
`endif
      end
      if (if_valid && !if_ready && !flush && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign id_valid         = vld_q;
  assign id_pc            = id_q.pc;
  assign id_rs1           = id_q.rs1;
  assign id_rs2           = id_q.rs2;
  assign id_rd            = id_q.rd;
  assign id_rd1           = id_q.rd1;
  assign id_rd2           = id_q.rd2;
  assign id_imm           = id_q.imm;
  assign id_branch_target = id_q.btgt;
  assign id_ctrl          = id_q.ctrl;
  assign id_illegal_reg   = id_q.illegal;
  assign id_stall_cnt     = stall_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe. Two instances share all inputs:
// dut (NREGS=32, CNT_W=16) and dut_e (NREGS=16, CNT_W=2, for illegal-index
// and counter-saturation checks).
module tb_id_stage_pipe;
`ifdef ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] ADDI1 = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] LW5   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD65 = 32'h0012_8333; // add  x6,x5,x1
  localparam logic [31:0] LW0   = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD60 = 32'h0010_0333; // add  x6,x0,x1
  localparam logic [31:0] ADD87 = 32'h0003_8433; // add  x8,x7,x0
  localparam logic [31:0] ADD20 = 32'h0018_8A33; // add  x20,x17,x1

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, if_valid = 1'b0, id_ready = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0, wb_reg_write_data = '0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_reg_write_rd = '0;

  logic        if_ready, id_valid, id_illegal_reg;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm, id_branch_target;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [27:0] id_ctrl;
  logic [15:0] id_stall_cnt;

  logic        e_if_ready, e_id_valid, e_id_illegal_reg;
  logic [31:0] e_id_pc, e_id_rd1, e_id_rd2, e_id_imm, e_id_branch_target;
  logic [4:0]  e_id_rs1, e_id_rs2, e_id_rd;
  logic [27:0] e_id_ctrl;
  logic [1:0]  e_id_stall_cnt;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.NREGS(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .wb_reg_write(wb_reg_write),
    .wb_reg_write_rd(wb_reg_write_rd), .wb_reg_write_data(wb_reg_write_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_branch_target(id_branch_target), .id_ctrl(id_ctrl),
    .id_illegal_reg(id_illegal_reg), .id_stall_cnt(id_stall_cnt)
  );

  id_stage_pipe #(.NREGS(16), .CNT_W(2)) dut_e (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(e_if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .wb_reg_write(wb_reg_write),
    .wb_reg_write_rd(wb_reg_write_rd), .wb_reg_write_data(wb_reg_write_data),
    .id_valid(e_id_valid), .id_ready(id_ready), .id_pc(e_id_pc), .id_rs1(e_id_rs1),
    .id_rs2(e_id_rs2), .id_rd(e_id_rd), .id_rd1(e_id_rd1), .id_rd2(e_id_rd2),
    .id_imm(e_id_imm), .id_branch_target(e_id_branch_target), .id_ctrl(e_id_ctrl),
    .id_illegal_reg(e_id_illegal_reg), .id_stall_cnt(e_id_stall_cnt)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_reg_write = 1'b1; wb_reg_write_rd = r; wb_reg_write_data = d;
    tick();
    wb_reg_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_valid = 1'b1; if_instr = ADDI1; if_pc = 32'h40; id_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0h exp 0", id_valid); end
    n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h exp 0", id_pc); end
    n_cmp++; if (id_ctrl !== 28'h0) begin n_err++; $display("FAIL rst_ctrl got %h exp 0", id_ctrl); end
    n_cmp++; if (id_imm !== 32'h0) begin n_err++; $display("FAIL rst_imm got %h exp 0", id_imm); end
    n_cmp++; if (id_stall_cnt !== 16'h0) begin n_err++; $display("FAIL rst_stall got %0d exp 0", id_stall_cnt); end
    n_cmp++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL rst_if_ready got %0h exp 0", if_ready); end
    rst = 1'b0; if_valid = 1'b0;
    wb(5'd1, 32'h0000_1000);
    wb(5'd7, 32'h0000_0077);
    wb(5'd17, 32'h0000_1717);
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pc = 32'h100 + 32'(4 * k);
      if_valid = 1'b1; if_pc = pc;
      if_instr = {12'(5 + k), 5'd0, 3'b000, 5'(k + 1), 7'b0010011};
      #1;
      n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL stream_if_ready[%0d] got %0h exp 1", k, if_ready); end
      if (k == 0) begin
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency got %0h exp 0", id_valid); end
      end
      tick();
      n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %0h exp 1", k, id_valid); end
      n_cmp++; if (id_pc !== pc) begin n_err++; $display("FAIL stream_pc[%0d] got %h exp %h", k, id_pc, pc); end
      n_cmp++; if (id_imm !== 32'(5 + k)) begin n_err++; $display("FAIL stream_imm[%0d] got %h exp %h", k, id_imm, 5 + k); end
      n_cmp++; if (id_rd !== 5'(k + 1)) begin n_err++; $display("FAIL stream_rd[%0d] got %0d exp %0d", k, id_rd, k + 1); end
      n_cmp++; if (id_ctrl !== 28'h000_6404) begin n_err++; $display("FAIL stream_ctrl[%0d] got %h exp 0006404", k, id_ctrl); end
      n_cmp++; if (id_branch_target !== pc + 32'(5 + k)) begin n_err++; $display("FAIL stream_btgt[%0d] got %h exp %h", k, id_branch_target, pc + 32'(5 + k)); end
    end
    if_valid = 1'b0;
    tick();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got %0h exp 0", id_valid); end
    n_cmp++; if (id_pc !== 32'h10C) begin n_err++; $display("FAIL stream_pc_keep got %h exp 10c", id_pc); end
    n_cmp++; if (id_stall_cnt !== 16'd0) begin n_err++; $display("FAIL stream_stall got %0d exp 0", id_stall_cnt); end
  endtask

  task automatic test_load_use();
    id_ready = 1'b1; if_valid = 1'b1; if_instr = LW5; if_pc = 32'h200;
    tick();
    n_cmp++; if (id_ctrl !== 28'h00_805FD) begin n_err++; $display("FAIL lu_ctrl got %h exp 00805fd", id_ctrl); end
    n_cmp++; if (id_rd1 !== 32'h1000) begin n_err++; $display("FAIL lu_rd1 got %h exp 1000", id_rd1); end
    if_instr = ADD65; if_pc = 32'h204;
    #1;
    n_cmp++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL lu_if_ready got %0h exp 0", if_ready); end
    tick();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble got %0h exp 0", id_valid); end
    n_cmp++; if (id_stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall got %0d exp 1", id_stall_cnt); end
    n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL lu_accept got %0h exp 1", if_ready); end
    tick();
    if_valid = 1'b0;
    n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL lu_add_valid got %0h exp 1", id_valid); end
    n_cmp++; if (id_pc !== 32'h204) begin n_err++; $display("FAIL lu_add_pc got %h exp 204", id_pc); end
    n_cmp++; if (id_rd2 !== 32'h1000) begin n_err++; $display("FAIL lu_add_rd2 got %h exp 1000", id_rd2); end
    tick();
  endtask

  task automatic test_load_x0();
    id_ready = 1'b1; if_valid = 1'b1; if_instr = LW0; if_pc = 32'h300;
    tick();
    if_instr = ADD60; if_pc = 32'h304;
    #1;
    n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL x0_if_ready got %0h exp 1", if_ready); end
    tick();
    if_valid = 1'b0;
    n_cmp++; if (id_pc !== 32'h304) begin n_err++; $display("FAIL x0_pc got %h exp 304", id_pc); end
    n_cmp++; if (id_stall_cnt !== 16'd1) begin n_err++; $display("FAIL x0_stall got %0d exp 1", id_stall_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    id_ready = 1'b0; if_valid = 1'b1; if_instr = ADDI1; if_pc = 32'h400;
    tick();
    if_instr = ADD65; if_pc = 32'h404;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL hold_if_ready[%0d] got %0h exp 0", c, if_ready); end
      tick();
      n_cmp++; if (id_pc !== 32'h400 || id_valid !== 1'b1) begin n_err++; $display("FAIL hold_payload[%0d] got pc %h v %0h exp 400 1", c, id_pc, id_valid); end
    end
    n_cmp++; if (id_stall_cnt !== 16'd4) begin n_err++; $display("FAIL hold_stall got %0d exp 4", id_stall_cnt); end
    n_cmp++; if (e_id_stall_cnt !== 2'd3) begin n_err++; $display("FAIL stall_saturate got %0d exp 3", e_id_stall_cnt); end
    id_ready = 1'b1;
    #1;
    n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL b2b_if_ready got %0h exp 1", if_ready); end
    tick();
    if_valid = 1'b0;
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h404) begin n_err++; $display("FAIL b2b_replace got v %0h pc %h exp 1 404", id_valid, id_pc); end
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    id_ready = 1'b0; if_valid = 1'b1; if_instr = ADD87; if_pc = 32'h500;
    tick();
    if_valid = 1'b0;
    n_cmp++; if (id_rd1 !== 32'h77) begin n_err++; $display("FAIL byp_rd1_pre got %h exp 77", id_rd1); end
    wb(5'd7, 32'hDEAD_BEEF);
    exp = BYP ? 32'hDEAD_BEEF : 32'h77;
    n_cmp++; if (id_rd1 !== exp) begin n_err++; $display("FAIL byp_hold got %h exp %h", id_rd1, exp); end
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h500) begin n_err++; $display("FAIL byp_held got v %0h pc %h exp 1 500", id_valid, id_pc); end
    id_ready = 1'b1;
    tick();
    if_valid = 1'b1; if_pc = 32'h504;
    wb(5'd7, 32'h1234_5678);
    if_valid = 1'b0;
    exp = BYP ? 32'h1234_5678 : 32'hDEAD_BEEF;
    n_cmp++; if (id_rd1 !== exp) begin n_err++; $display("FAIL byp_same_cycle got %h exp %h", id_rd1, exp); end
    if_valid = 1'b1; if_pc = 32'h508;
    wb(5'd0, 32'hFFFF_FFFF);
    if_valid = 1'b0;
    n_cmp++; if (id_rd2 !== 32'h0) begin n_err++; $display("FAIL byp_x0 got %h exp 0", id_rd2); end
    tick();
  endtask

  task automatic test_flush();
    id_ready = 1'b0; if_valid = 1'b1; if_instr = ADDI1; if_pc = 32'h600;
    tick();
    if_instr = ADD65; if_pc = 32'h604; flush = 1'b1;
    #1;
    n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL flush_if_ready got %0h exp 1", if_ready); end
    tick();
    flush = 1'b0; if_valid = 1'b0;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0h exp 0", id_valid); end
    n_cmp++; if (id_pc !== 32'h600) begin n_err++; $display("FAIL flush_drop got %h exp 600", id_pc); end
    n_cmp++; if (id_stall_cnt !== 16'd4) begin n_err++; $display("FAIL flush_stall got %0d exp 4", id_stall_cnt); end
  endtask

  task automatic test_nregs16();
    id_ready = 1'b1; if_valid = 1'b1; if_instr = ADD20; if_pc = 32'h700;
    tick();
    if_valid = 1'b0;
    n_cmp++; if (e_id_illegal_reg !== 1'b1) begin n_err++; $display("FAIL e_illegal got %0h exp 1", e_id_illegal_reg); end
    n_cmp++; if (e_id_rd1 !== 32'h0) begin n_err++; $display("FAIL e_rd1 got %h exp 0", e_id_rd1); end
    n_cmp++; if (e_id_rd2 !== 32'h1000) begin n_err++; $display("FAIL e_rd2 got %h exp 1000", e_id_rd2); end
    n_cmp++; if (id_illegal_reg !== 1'b0) begin n_err++; $display("FAIL i_illegal got %0h exp 0", id_illegal_reg); end
    n_cmp++; if (id_rd1 !== 32'h1717) begin n_err++; $display("FAIL i_rd1 got %h exp 1717", id_rd1); end
    tick();
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b0; if_valid = 1'b1; if_instr = ADDI1; if_pc = 32'h800;
    tick();
    rst = 1'b1;
    tick();
    if_valid = 1'b0;
    n_cmp++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_rd1 !== 32'h0) begin n_err++; $display("FAIL mid_rst got v %0h pc %h rd1 %h exp 0 0 0", id_valid, id_pc, id_rd1); end
    n_cmp++; if (id_stall_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_stall got %0d exp 0", id_stall_cnt); end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_stream();
    test_load_use();
    test_load_x0();
    test_back_to_back();
    test_bypass();
    test_flush();
    test_nregs16();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
